// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the channel sources and the mux select arbiter.
// The master side drives requests; the slave side (the arbiter) returns the grant.
interface mux_sel_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       valid;
    logic       s0;
    logic       s1;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  valid,
        input  s0,
        input  s1,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output valid,
        output s0,
        output s1,
        output timeout
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Four-channel round-robin arbiter driving the 4:1 mux selects, with a hold-time
// limit that forces rotation and a back-to-back handover between owners.
module mux_sel_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux_sel_arbiter_if.slave    bus
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       owner;
    logic [3:0]       owner_bit;
    logic             rel_mask;
    logic             hold_hit;
    logic [3:0]       cand;
    logic [2:0]       pick;

    // Returns {found, index}; scans from+1 .. from+3, then from itself last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;

        owner     = sel_q;
        owner_bit = 4'b0001 << owner;
        rel_mask  = bus.done || !bus.req[owner];
        hold_hit  = (cnt_q == CNT_W'(HOLD_MAX));
        cand      = rel_mask ? (bus.req & ~owner_bit) : bus.req;
        pick      = 3'b000;

        unique case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, last_q);
                if (pick[2]) begin
                    grant_d = 4'b0001 << pick[1:0];
                    sel_d   = pick[1:0];
                    valid_d = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel_mask || hold_hit) begin
                    last_d = owner;
                    // A pure hold-limit release leaves the owner eligible at lowest priority.
                    pick      = rr_pick(cand, owner);
                    timeout_d = !rel_mask;
                    if (pick[2]) begin
                        grant_d = 4'b0001 << pick[1:0];
                        sel_d   = pick[1:0];
                        valid_d = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.valid   = valid_q;
    assign bus.s0      = sel_q[0];
    assign bus.s1      = sel_q[1];
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural owner/last/hold-count model.
module tb_mux_sel_arbiter;

    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: owner is -1 when idle.
    int m_own  = -1;
    int m_last = 3;
    int m_cnt  = 0;
    int m_sel  = 0;
    int m_to   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_first(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic d, input logic rs);
        logic [3:0] cand;
        bit         drop;
        bit         lim;
        if (rs) begin
            m_own = -1; m_last = 3; m_cnt = 0; m_sel = 0; m_to = 0;
        end else if (m_own < 0) begin
            m_to = 0;
            if (r != 4'b0000) begin
                m_own = rr_first(r, m_last);
                m_sel = m_own;
                m_cnt = 1;
            end
        end else begin
            m_to = 0;
            drop = d || !r[m_own];
            lim  = (m_cnt == HOLD);
            if (drop || lim) begin
                m_last = m_own;
                cand   = r;
                if (drop) cand[m_own] = 1'b0;
                if (!drop) m_to = 1;
                if (cand != 4'b0000) begin
                    m_own = rr_first(cand, m_last);
                    m_sel = m_own;
                    m_cnt = 1;
                end else begin
                    m_own = -1;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Apply inputs, take one edge, then compare all outputs 1ns later.
    task automatic step(input logic [3:0] r, input logic d);
        logic [3:0] exp_g;
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_edge(r, d, rst);
        #1;
        exp_g = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
        check_eq("grant",   32'(bus.grant), 32'(exp_g));
        check_eq("valid",   32'(bus.valid), 32'(m_own >= 0));
        check_eq("sel",     32'({bus.s1, bus.s0}), 32'(m_sel));
        check_eq("timeout", 32'(bus.timeout), 32'(m_to));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        rst = 1'b0;
    endtask

    logic [3:0] rr_exp [5];
    int         to_cnt;
    logic [3:0] rq;
    logic       dn;

    initial begin
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        #2;

        // Idle after reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0);
            check_eq("idle_grant", 32'(bus.grant), 32'h0);
            check_eq("idle_sel", 32'({bus.s1, bus.s0}), 32'h0);
        end

        // Round-robin order with done every second cycle
        do_reset();
        step(4'b1111, 1'b0);
        check_eq("rr_0", 32'(bus.grant), 32'(rr_exp[0]));
        for (int i = 1; i < 5; i++) begin
            step(4'b1111, 1'b1);
            check_eq("rr_grant", 32'(bus.grant), 32'(rr_exp[i]));
            check_eq("rr_sel", 32'({bus.s1, bus.s0}), 32'(i % 4));
            step(4'b1111, 1'b0);
            check_eq("rr_hold", 32'(bus.grant), 32'(rr_exp[i]));
        end

        // Sole requester hits the hold limit and is re-granted
        do_reset();
        to_cnt = 0;
        for (int i = 1; i <= 2 * HOLD + 1; i++) begin
            step(4'b0100, 1'b0);
            check_eq("sole_grant", 32'(bus.grant), 32'h4);
            if (bus.timeout) to_cnt++;
            if (i == HOLD + 1) check_eq("sole_to_edge", 32'(bus.timeout), 32'h1);
        end
        check_eq("sole_to_count", 32'(to_cnt), 32'd2);

        // Owner 1 drops its request, channel 3 takes over
        do_reset();
        step(4'b0010, 1'b0);
        step(4'b1010, 1'b0);
        check_eq("drop_pre", 32'(bus.grant), 32'h2);
        step(4'b1000, 1'b0);
        check_eq("drop_grant", 32'(bus.grant), 32'h8);
        check_eq("drop_sel", 32'({bus.s1, bus.s0}), 32'd3);
        check_eq("drop_to", 32'(bus.timeout), 32'h0);

        // Owner 3 released to idle, selects held, then channel 0 wins
        do_reset();
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b1);
        check_eq("rel_valid", 32'(bus.valid), 32'h0);
        check_eq("rel_sel", 32'({bus.s1, bus.s0}), 32'd3);
        step(4'b1001, 1'b0);
        check_eq("rel_next", 32'(bus.grant), 32'h1);

        // Reset in the middle of a grant
        step(4'b1111, 1'b1);
        rst = 1'b1;
        step(4'b1111, 1'b0);
        check_eq("mid_rst_grant", 32'(bus.grant), 32'h0);
        check_eq("mid_rst_sel", 32'({bus.s1, bus.s0}), 32'h0);
        rst = 1'b0;
        step(4'b1111, 1'b0);
        check_eq("post_rst_grant", 32'(bus.grant), 32'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rq  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rq = 4'b0000;
            dn  = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step(rq, dn);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
